m_element_supplier: RTL

- Responder for the second stage's m-element request interface.
- Each request pulse on m_element_requested yields one burst of ROW_LEN weight elements, read in order from a synchronous weight ROM. Elements are presented with m_element_ready, and the final element of each burst is flagged with last_m_element.
- Requests that arrive while a burst is in progress are queued.
- The block asserts finished once all NUM_ROWS bursts have been delivered.

---
 rtl/m_element_supplier.sv | 97 +++++++++
 1 files changed

// File: rtl/m_element_supplier.sv
// m_element_supplier: streams weight-ROM bursts in response to queued m-element requests
module m_element_supplier #(
  parameter int ROW_LEN    = 8,
  parameter int NUM_ROWS   = 64,
  parameter int ADDR_WIDTH = 9,
  parameter int PEND_MAX   = 7
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic                  en,
  input  logic                  m_element_requested,
  output logic [ADDR_WIDTH-1:0] weight_rom_address,
  output logic                  weight_rom_enable,
  input  logic [15:0]           weight_rom_data,
  output logic [15:0]           m_element,
  output logic                  m_element_ready,
  output logic                  last_m_element,
  output logic                  request_overflow,
  output logic                  finished
);
  localparam int PW = $clog2(PEND_MAX + 1);
  localparam int IW = $clog2(ROW_LEN);
  localparam int RW = $clog2(NUM_ROWS + 1);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} t_state;
  t_state                r_state;
  logic [PW-1:0]         r_pending;
  logic [IW-1:0]         r_idx;
  logic [RW-1:0]         r_rows;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_v1, r_l1, r_v2, r_l2;
  logic [15:0]           r_m_element;
  logic                  r_overflow, r_finished;
  logic                  w_req, w_any, w_read, w_row_end, w_all_done, w_launch, w_drop;
  assign w_req      = m_element_requested & ~r_finished;
  assign w_any      = (r_pending != '0) | w_req;
  assign w_read     = en & (r_state == READ);
  assign w_row_end  = w_read & (r_idx == IW'(ROW_LEN - 1));
  assign w_all_done = w_row_end & (r_rows == RW'(NUM_ROWS - 1));
  assign w_launch   = en & w_any & ((r_state == IDLE) | (w_row_end & ~w_all_done));
  assign w_drop     = w_req & ~w_launch & (r_pending == PW'(PEND_MAX));
  assign weight_rom_address = r_addr;
  assign weight_rom_enable  = w_read;
  assign m_element          = r_m_element;
  assign m_element_ready    = r_v2 & en;
  assign last_m_element     = r_v2 & r_l2 & en;
  assign request_overflow   = r_overflow;
  assign finished           = r_finished;
  // request queue, read sequencing, two-stage output pipeline and burst FSM
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_state     <= IDLE;
      r_pending   <= '0;
      r_idx       <= '0;
      r_rows      <= '0;
      r_addr      <= '0;
      r_v1        <= 1'b0;
      r_l1        <= 1'b0;
      r_v2        <= 1'b0;
      r_l2        <= 1'b0;
      r_m_element <= '0;
      r_overflow  <= 1'b0;
      r_finished  <= 1'b0;
    end else begin
      if (w_req & ~w_launch & ~w_drop)
        r_pending <= r_pending + PW'(1);
      else if (~w_req & w_launch)
        r_pending <= r_pending - PW'(1);
      if (w_drop)
        r_overflow <= 1'b1;
      if (en) begin
        r_v1 <= w_read;
        r_l1 <= w_row_end;
        r_v2 <= r_v1;
        r_l2 <= r_l1;
        if (r_v1)
          r_m_element <= weight_rom_data;
      end
      if (w_read) begin
        r_addr <= w_all_done ? r_addr : r_addr + ADDR_WIDTH'(1);
        r_idx  <= w_row_end ? '0 : r_idx + IW'(1);
      end
      if (w_row_end)
        r_rows <= r_rows + RW'(1);
      case (r_state)
        IDLE:    r_state <= w_launch ? READ : IDLE;
        READ:    r_state <= !w_row_end ? READ : w_all_done ? DRAIN : w_any ? READ : IDLE;
        DRAIN: begin
          if (en & ~r_v1) begin
            r_state    <= DONE;
            r_finished <= 1'b1;
          end
        end
        default: r_state <= DONE;
      endcase
    end
  end
endmodule
